// File: rtl/jamma_input_scanner.sv
// jamma_input_scanner: drives JSELECT, demultiplexes the shared JJOY bus into
// per-player words, debounces every button with a saturating integrator, and
// synchronises / pulse-stretches the two coin inputs. All outputs active low.
//
// state     | meaning
// P1_SETTLE | jselect=0, waiting for the adaptor mux to settle
// P1_SAMPLE | capture jjoy as the raw player-1 word
// P2_SETTLE | jselect=1, waiting for the adaptor mux to settle
// P2_SAMPLE | capture jjoy as the raw player-2 word
module jamma_input_scanner #(
  parameter int SETTLE_CYCLES = 4,
  parameter int DEBOUNCE_BITS = 4,
  parameter int COIN_HOLD     = 16
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic [7:0] jjoy,
  input  logic [1:0] jcoin,
  output logic       jselect,
  output logic [7:0] joystick1,
  output logic [7:0] joystick2,
  output logic [1:0] coin,
  output logic       scan_done
);

  localparam logic [1:0] P1_SETTLE = 2'd0;
  localparam logic [1:0] P1_SAMPLE = 2'd1;
  localparam logic [1:0] P2_SETTLE = 2'd2;
  localparam logic [1:0] P2_SAMPLE = 2'd3;

  localparam logic [7:0]               SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [DEBOUNCE_BITS-1:0] CNT_MAX     = '1;
  localparam logic [DEBOUNCE_BITS-1:0] CNT_ZERO    = '0;
  localparam logic [DEBOUNCE_BITS-1:0] CNT_ONE     = DEBOUNCE_BITS'(1);
  localparam logic [15:0]              HOLD_LOAD   = 16'(COIN_HOLD - 1);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [7:0] settle_cnt;
  logic       in_settle;
  logic       settle_end;

  // index 0 = player 1, index 1 = player 2
  logic [1:0][7:0]                    raw;
  logic [1:0]                         upd;
  logic [1:0][7:0][DEBOUNCE_BITS-1:0] cnt;
  logic [1:0][7:0][DEBOUNCE_BITS-1:0] cnt_nxt;
  logic [1:0][7:0]                    word;
  logic [1:0][7:0]                    word_nxt;

  logic [1:0]       coin_meta;
  logic [1:0]       coin_sync;
  logic [1:0][15:0] coin_hold;

  assign in_settle  = (state == P1_SETTLE) || (state == P2_SETTLE);
  assign settle_end = (settle_cnt == SETTLE_LAST);

  // Scan sequencing: each SETTLE lasts SETTLE_CYCLES, each SAMPLE one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      P1_SETTLE: if (settle_end) state_nxt = P1_SAMPLE;
      P1_SAMPLE: state_nxt = P2_SETTLE;
      P2_SETTLE: if (settle_end) state_nxt = P2_SAMPLE;
      default:   state_nxt = P1_SETTLE;
    endcase
  end

  // State, settle counter and registered mux select (bit 1 of state = player 2).
  always_ff @(posedge pclk) begin
    if (reset) begin
      state      <= P1_SETTLE;
      settle_cnt <= 8'd0;
      jselect    <= 1'b0;
    end else begin
      state      <= state_nxt;
      jselect    <= state_nxt[1];
      settle_cnt <= (in_settle && !settle_end) ? settle_cnt + 8'd1 : 8'd0;
    end
  end

  // Raw capture in SAMPLE states; the integrators run on the following cycle.
  always_ff @(posedge pclk) begin
    if (reset) begin
      raw <= '1;
      upd <= 2'b00;
    end else begin
      upd[0] <= (state == P1_SAMPLE);
      upd[1] <= (state == P2_SAMPLE);
      if (state == P1_SAMPLE) raw[0] <= jjoy;
      if (state == P2_SAMPLE) raw[1] <= jjoy;
    end
  end

  // Saturating per-bit integrators; outputs only flip at the rails.
  always_comb begin
    cnt_nxt  = cnt;
    word_nxt = word;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        if (!raw[p][i] && (cnt[p][i] != CNT_ZERO))
          cnt_nxt[p][i] = cnt[p][i] - CNT_ONE;
        else if (raw[p][i] && (cnt[p][i] != CNT_MAX))
          cnt_nxt[p][i] = cnt[p][i] + CNT_ONE;
        if (cnt_nxt[p][i] == CNT_ZERO)
          word_nxt[p][i] = 1'b0;
        else if (cnt_nxt[p][i] == CNT_MAX)
          word_nxt[p][i] = 1'b1;
      end
    end
  end

  // Commit a player's integrators only on its update cycle.
  always_ff @(posedge pclk) begin
    if (reset) begin
      cnt  <= {2{{8{CNT_MAX}}}};
      word <= '1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (upd[p]) begin
          cnt[p]  <= cnt_nxt[p];
          word[p] <= word_nxt[p];
        end
      end
    end
  end

  assign joystick1 = word[0];
  assign joystick2 = word[1];
  assign scan_done = upd[1];

  // Coin path: 2-FF synchroniser, then a hold counter that stretches short
  // presses to COIN_HOLD cycles. Only a fresh press (coin idle) loads the
  // counter, so a long hold keeps coin low exactly as long as it is held.
  always_ff @(posedge pclk) begin
    if (reset) begin
      coin_meta <= 2'b11;
      coin_sync <= 2'b11;
      coin_hold <= '0;
      coin      <= 2'b11;
    end else begin
      coin_meta <= jcoin;
      coin_sync <= coin_meta;
      for (int b = 0; b < 2; b++) begin
        if (coin[b] && !coin_sync[b]) begin
          coin_hold[b] <= HOLD_LOAD;
          coin[b]      <= 1'b0;
        end else if (coin_hold[b] != 16'd0) begin
          coin_hold[b] <= coin_hold[b] - 16'd1;
          coin[b]      <= 1'b0;
        end else begin
          coin[b] <= coin_sync[b];
        end
      end
    end
  end

endmodule

// File: tb/tb_jamma_input_scanner.sv
// Self-checking bench for jamma_input_scanner at default parameters.
module tb_jamma_input_scanner;

  localparam int HOLD   = 16;
  localparam int MAXC   = 15;
  localparam int PERIOD = 10;
  localparam int NC     = 1500;

  logic       pclk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] jjoy;
  logic [1:0] jcoin = 2'b11;
  logic       jselect;
  logic [7:0] joystick1;
  logic [7:0] joystick2;
  logic [1:0] coin;
  logic       scan_done;

  logic [7:0] p1_word = 8'hFF;
  logic [7:0] p2_word = 8'hFF;

  int vectors = 0;
  int errors  = 0;

  int         m_cnt [2][8];
  logic [7:0] m_out [2];
  logic [1:0] stim [NC];

  // adaptor model: the mux presents the selected player's word
  assign jjoy = jselect ? p2_word : p1_word;

  always #5 pclk = ~pclk;

  jamma_input_scanner dut (
    .pclk      (pclk),
    .reset     (reset),
    .jjoy      (jjoy),
    .jcoin     (jcoin),
    .jselect   (jselect),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .coin      (coin),
    .scan_done (scan_done)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) m_cnt[p][i] = MAXC;
      m_out[p] = 8'hFF;
    end
  endtask

  // one scan's worth of samples: saturating count, output switches at 0 / MAX
  task automatic model_scan();
    logic [7:0] w;
    for (int p = 0; p < 2; p++) begin
      w = (p == 0) ? p1_word : p2_word;
      for (int i = 0; i < 8; i++) begin
        if (w[i]) m_cnt[p][i] = (m_cnt[p][i] < MAXC) ? m_cnt[p][i] + 1 : MAXC;
        else      m_cnt[p][i] = (m_cnt[p][i] > 0) ? m_cnt[p][i] - 1 : 0;
        if (m_cnt[p][i] == 0)         m_out[p][i] = 1'b0;
        else if (m_cnt[p][i] == MAXC) m_out[p][i] = 1'b1;
      end
    end
  endtask

  // leaves the bench at the negedge of the first cycle after reset
  task automatic reset_dut();
    @(negedge pclk);
    reset = 1'b1;
    repeat (2) @(negedge pclk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_scan_done();
    int n;
    n = 0;
    while (scan_done !== 1'b1 && n < 3 * PERIOD) begin
      @(negedge pclk);
      n++;
    end
    chk("scan_done_seen", {7'b0, scan_done}, 8'h01);
  endtask

  // waits for the current scan to complete and checks both words after it
  task automatic do_scan(input string tag);
    wait_scan_done();
    model_scan();
    @(negedge pclk);
    chk({tag, "_joy1"}, joystick1, m_out[0]);
    chk({tag, "_joy2"}, joystick2, m_out[1]);
  endtask

  initial begin
    logic [7:0] t1, t2;
    int         pos, len, b;
    logic       lvl;
    logic [1:0] m_coin;
    int         m_start [2];
    logic [1:0] d;

    model_reset();

    // reset values
    repeat (3) @(negedge pclk);
    chk("rst_jselect", {7'b0, jselect}, 8'h00);
    chk("rst_joy1", joystick1, 8'hFF);
    chk("rst_joy2", joystick2, 8'hFF);
    chk("rst_coin", {6'b0, coin}, 8'h03);
    chk("rst_scan_done", {7'b0, scan_done}, 8'h00);

    // idle scan cadence: jselect 0 x5 / 1 x5, scan_done every 10 cycles
    reset = 1'b0;
    for (int k = 0; k < 3 * PERIOD; k++) begin
      chk("idle_jselect", {7'b0, jselect}, ((k % PERIOD) >= 5) ? 8'h01 : 8'h00);
      chk("idle_scan_done", {7'b0, scan_done}, (k >= PERIOD && (k % PERIOD) == 0) ? 8'h01 : 8'h00);
      chk("idle_words", joystick1 & joystick2, 8'hFF);
      @(negedge pclk);
    end

    // player-1 bit 0 held: output flips on exactly the 15th scan
    p1_word = 8'hFE;
    p2_word = 8'hFF;
    reset_dut();
    for (int s = 1; s <= 16; s++) begin
      do_scan("press_p1");
      if (s == 14) chk("press_p1_scan14", joystick1, 8'hFF);
      if (s == 15) chk("press_p1_scan15", joystick1, 8'hFE);
    end

    // randomized words: slowly moving targets with single-bit glitches
    p1_word = 8'hFF;
    p2_word = 8'hFF;
    reset_dut();
    t1 = 8'hFF;
    t2 = 8'hFF;
    for (int s = 0; s < 300; s++) begin
      do_scan("rand");
      if ($urandom_range(0, 23) == 0) t1 = 8'($urandom);
      if ($urandom_range(0, 23) == 0) t2 = 8'($urandom);
      p1_word = t1;
      p2_word = t2;
      if ($urandom_range(0, 3) == 0) p1_word[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0) p2_word[$urandom_range(0, 7)] ^= 1'b1;
    end

    // reset in P2_SETTLE with player 1 part-way integrated
    p1_word = 8'h00;
    p2_word = 8'hFF;
    reset_dut();
    for (int s = 0; s < 8; s++) do_scan("half_p1");
    repeat (5) @(negedge pclk);
    chk("mid_jselect_p2", {7'b0, jselect}, 8'h01);
    reset = 1'b1;
    @(negedge pclk);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_jselect", {7'b0, jselect}, 8'h00);
    chk("mid_rst_joy1", joystick1, 8'hFF);
    chk("mid_rst_scan_done", {7'b0, scan_done}, 8'h00);
    for (int s = 1; s <= 15; s++) begin
      do_scan("restart_p1");
      if (s == 14) chk("restart_scan14", joystick1, 8'hFF);
      if (s == 15) chk("restart_scan15", joystick1, 8'h00);
    end

    // coin stimulus: directed 2-cycle tap and 40-cycle hold, then random runs
    for (int j = 0; j < NC; j++) stim[j] = 2'b11;
    stim[5][0] = 1'b0;
    stim[6][0] = 1'b0;
    for (int j = 10; j < 50; j++) stim[j][1] = 1'b0;
    for (b = 0; b < 2; b++) begin
      pos = 80;
      lvl = 1'b1;
      while (pos < NC - 50) begin
        len = lvl ? $urandom_range(1, 30) : $urandom_range(1, 40);
        for (int j = pos; j < pos + len && j < NC - 50; j++) stim[j][b] = lvl;
        pos += len;
        lvl = ~lvl;
      end
    end

    p1_word = 8'hFF;
    p2_word = 8'hFF;
    reset_dut();
    m_coin = 2'b11;
    m_start[0] = 0;
    m_start[1] = 0;
    for (int j = 0; j < NC; j++) begin
      d = (j >= 3) ? stim[j-3] : 2'b11;
      for (int k = 0; k < 2; k++) begin
        if (m_coin[k] && !d[k]) begin
          m_start[k] = j;
          m_coin[k]  = 1'b0;
        end else if (!m_coin[k]) begin
          m_coin[k] = ((j - m_start[k]) < HOLD || !d[k]) ? 1'b0 : 1'b1;
        end
      end
      chk("coin", {6'b0, coin}, {6'b0, m_coin});
      jcoin = stim[j];
      @(negedge pclk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/jamma_input_scanner.md
Name: jamma_input_scanner

Overview:
Upstream input stage for the JAMMA arcade cores. Drives the JSELECT mux line on the JAMMA adaptor and time-demultiplexes the shared 8-bit JJOY bus into per-player words. Debounces every button per player, synchronises and pulse-stretches the two coin inputs, and presents clean active-low joystick1, joystick2 and coin words to the core instance.

Parameters:
SETTLE_CYCLES, 4, pclk cycles the mux is held after a JSELECT change before JJOY is sampled; legal range 1..255.
DEBOUNCE_BITS, 4, width of the per-bit debounce integrator; MAX = 2^DEBOUNCE_BITS-1; legal range 1..8.
COIN_HOLD, 16, minimum active-low width of a coin output pulse, in pclk cycles; legal range 1..65535.

Ports:
pclk  in  1  system pixel clock; single clock domain.
reset  in  1  synchronous, active-high reset.
jjoy  in  8  multiplexed JAMMA joystick/button bus, active low, asynchronous.
jcoin  in  2  coin switches, active low, asynchronous.
jselect  out  1  mux select to the adaptor: 0 = player 1, 1 = player 2.
joystick1  out  8  debounced player-1 word, active low.
joystick2  out  8  debounced player-2 word, active low.
coin  out  2  synchronised, stretched coin, active low.
scan_done  out  1  one-cycle strobe after both player words have been updated.

Behaviour:
- Reset values, applied on the first edge with reset=1:
  - jselect=0, joystick1=8'hFF, joystick2=8'hFF, coin=2'b11, scan_done=0.
  - All integrators = MAX; settle counter = 0; FSM state = P1_SETTLE; coin synchronisers = 1.
- FSM states: P1_SETTLE, P1_SAMPLE, P2_SETTLE, P2_SAMPLE.
  - P1_SETTLE: jselect=0. Counter increments each cycle. When it reaches SETTLE_CYCLES-1, go to P1_SAMPLE and clear the counter.
  - P1_SAMPLE: capture jjoy into raw1 (1 cycle). Go to P2_SETTLE.
  - P2_SETTLE: jselect=1. Same counting as P1_SETTLE, exit to P2_SAMPLE.
  - P2_SAMPLE: capture jjoy into raw2. Go to P1_SETTLE.
  - jselect is registered from the state and changes on the first cycle of each SETTLE state.
  - Full scan period = 2*(SETTLE_CYCLES+1) cycles; 10 at default.
- Debounce, per bit, evaluated on the cycle after that player's SAMPLE:
  - Raw bit 0 and cnt>0: cnt decrements. Raw bit 1 and cnt<MAX: cnt increments. Counts saturate at 0 and MAX.
  - Output bit goes to 0 when the new cnt==0, goes to 1 when the new cnt==MAX, otherwise holds.
  - Press from idle: output goes low after MAX consecutive low samples of that player.
  - A single-sample glitch never changes the output when MAX>1.
  - Player 1 and player 2 integrators are fully independent; a player-2 sample never touches player-1 state.
- scan_done pulses high in the same cycle joystick2 may update, i.e. the cycle after P2_SAMPLE.
- Coin path, per bit:
  - jcoin passes through a 2-FF synchroniser (reset value 1).
  - When the synced value is 0 and the hold counter is 0, load the counter with COIN_HOLD-1 and drive coin=0.
  - While counter>0, decrement and keep coin=0.
  - coin returns to 1 on the first cycle where counter==0 and the synced input is 1.
  - A held coin stays low for as long as it is held. A re-press during a hold extends nothing beyond the hold.
  - Latency from jcoin falling to coin falling = 3 cycles.
- Reset mid-scan: the partial sample is discarded. The next cycle after reset deasserts is P1_SETTLE with counter 0 and jselect=0.
- jjoy is sampled only in SAMPLE states; transitions on jjoy during SETTLE have no effect.

Test Plan:
- Reset release, jjoy=8'hFF: jselect shows the pattern 0 for 5 cycles, 1 for 5 cycles, repeating. scan_done pulses every 10 cycles. Outputs remain 8'hFF/2'b11.
- Adaptor model driving 8'hFE when jselect=0 and 8'hFF when jselect=1: joystick1 becomes 8'hFE after exactly 15 scans. joystick2 stays 8'hFF throughout.
- DEBOUNCE_BITS=2, player 2 bit 4 low for one scan then high: joystick2 stays 8'hFF. Low for 3 consecutive scans: joystick2=8'hEF. Released for 3 scans: back to 8'hFF.
- jcoin[0] low for 2 cycles, COIN_HOLD=16: coin[0] falls 3 cycles later and stays 0 for exactly 16 cycles. coin[1] stays 1.
- jcoin[1] held low 40 cycles: coin[1] low for 40 cycles, delayed by 3.
- Assert reset during P2_SETTLE with player 1 half-integrated: next cycle jselect=0, joystick1=8'hFF, and the integration restarts from MAX.
